// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with fill level, programmable almost flags, a read-valid strobe and sticky errors.
// Read data is registered with 1-cycle latency; a write when full or a read when empty is dropped and flagged.
module sync_fifo_flags #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 10,
    parameter int AF_LEVEL = 2**ADDR_W - 4,
    parameter int AE_LEVEL = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              r_en,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] AF_L = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_L = (ADDR_W+1)'(AE_LEVEL);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   w_ptr;
    logic [ADDR_W:0]   r_ptr;
    logic              wr_acc;
    logic              rd_acc;

    // The extra MSB on each pointer separates full from empty when the low bits match.
    assign empty        = (w_ptr == r_ptr);
    assign full         = (w_ptr[ADDR_W] != r_ptr[ADDR_W]) &&
                          (w_ptr[ADDR_W-1:0] == r_ptr[ADDR_W-1:0]);
    assign count        = w_ptr - r_ptr;
    assign almost_full  = (count >= AF_L);
    assign almost_empty = (count <= AE_L);

    assign wr_acc = w_en && !full;
    assign rd_acc = r_en && !empty;

    // Storage is never cleared by reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (rst && wr_acc) begin
            mem[w_ptr[ADDR_W-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            w_ptr     <= '0;
            r_ptr     <= '0;
            data_out  <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (wr_acc) begin
                w_ptr <= w_ptr + 1'b1;
            end
            if (rd_acc) begin
                data_out <= mem[r_ptr[ADDR_W-1:0]];
                r_ptr    <= r_ptr + 1'b1;
            end
            // A new error event in the same cycle as clr_err keeps the flag set.
            if (w_en && full) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (r_en && empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags (depth 4): expected read words are queued at issue time,
// and a negedge monitor pops and compares them whenever rd_valid is seen.
module tb_sync_fifo_flags;

    logic        clk;
    logic        rst;
    logic        w_en;
    logic [31:0] data_in;
    logic        r_en;
    logic [31:0] data_out;
    logic        rd_valid;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic        almost_empty;
    logic [2:0]  count;
    logic        overflow;
    logic        underflow;
    logic        clr_err;

    int checks = 0;
    int passed = 0;
    logic [31:0] exp_q[$];

    sync_fifo_flags #(
        .DATA_W  (32),
        .ADDR_W  (2),
        .AF_LEVEL(3),
        .AE_LEVEL(1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .w_en        (w_en),
        .data_in     (data_in),
        .r_en        (r_en),
        .data_out    (data_out),
        .rd_valid    (rd_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow),
        .clr_err     (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One clock of stimulus; returns #1 after the capturing edge with inputs idle.
    task automatic step(input logic w, input logic [31:0] d, input logic r, input logic c);
        w_en = w; data_in = d; r_en = r; clr_err = c;
        @(posedge clk);
        #1;
        w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0;
    endtask

    task automatic wr(input logic [31:0] d);
        step(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [31:0] exp_d);
        exp_q.push_back(exp_d);
        step(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    // Monitor: every rd_valid must match the oldest outstanding expected word.
    initial begin
        forever begin
            @(negedge clk);
            if (rd_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL rd_data: got rd_valid with data 0x%0h, expected no read", data_out);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    if (data_out === e) passed++;
                    else $display("FAIL rd_data: got 0x%0h, expected 0x%0h", data_out, e);
                end
            end
        end
    end

    initial begin
        rst = 1'b0; w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0; data_in = '0;
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_aempty", 32'(almost_empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_afull", 32'(almost_full), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_unf", 32'(underflow), 0);
        chk("rst_dout", data_out, 0);
        chk("rst_rdv", 32'(rd_valid), 0);

        // Fill and drain in order
        wr(32'hA0); wr(32'hA1); wr(32'hA2);
        chk("w3_afull", 32'(almost_full), 1);
        chk("w3_aempty", 32'(almost_empty), 0);
        chk("w3_full", 32'(full), 0);
        wr(32'hA3);
        chk("w4_full", 32'(full), 1);
        chk("w4_count", 32'(count), 4);
        for (int i = 0; i < 4; i++) rd(32'hA0 + i);
        chk("drain_empty", 32'(empty), 1);
        chk("drain_count", 32'(count), 0);

        // Simultaneous write/read while full: write dropped, overflow set
        for (int i = 0; i < 4; i++) wr(32'hC0 + i);
        exp_q.push_back(32'hC0);
        step(1'b1, 32'hBB, 1'b1, 1'b0);
        chk("full_wr_ovf", 32'(overflow), 1);
        chk("full_wr_count", 32'(count), 3);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("clr_ovf", 32'(overflow), 0);
        for (int i = 1; i < 4; i++) rd(32'hC0 + i);
        chk("after_ovf_empty", 32'(empty), 1);

        // Simultaneous write/read while empty: read dropped, underflow set
        step(1'b1, 32'h55, 1'b1, 1'b0);
        chk("empty_rw_count", 32'(count), 1);
        chk("empty_rw_unf", 32'(underflow), 1);
        chk("empty_rw_rdv", 32'(rd_valid), 0);
        rd(32'h55);
        chk("unf_read_count", 32'(count), 0);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("clr_unf", 32'(underflow), 0);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("unf_set_wins", 32'(underflow), 1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("clr_unf2", 32'(underflow), 0);

        // Streaming across pointer wrap at a steady level of 2
        wr(32'hD0); wr(32'hD1);
        for (int i = 0; i < 12; i++) begin
            exp_q.push_back(i < 2 ? 32'hD0 + i : 32'hE0 + i - 2);
            step(1'b1, 32'hE0 + i, 1'b1, 1'b0);
            chk("wrap_count", 32'(count), 2);
            chk("wrap_flags", {30'd0, full, empty}, 0);
        end
        rd(32'hEA); rd(32'hEB);
        chk("wrap_empty", 32'(empty), 1);

        // Reset mid-operation discards contents and wins over a same-cycle read
        wr(32'hF0); wr(32'hF1); wr(32'hF2);
        chk("pre_rst_count", 32'(count), 3);
        rst = 1'b0;
        step(1'b1, 32'h99, 1'b1, 1'b0);
        rst = 1'b1;
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_empty", 32'(empty), 1);
        chk("mid_rst_rdv", 32'(rd_valid), 0);
        wr(32'h77);
        rd(32'h77);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);

        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
